// File: rtl/hzd_pkg.sv
// Shared types and mask helpers for the pipeline hazard controller.
// The mask helpers return a wide vector that callers slice down to NUM_STG bits.
package hzd_pkg;

    typedef enum logic [1:0] {
        HZ_RUN,
        HZ_MISS,
        HZ_LU
    } hz_state_t;

    localparam int HZD_MAX_STG = 32;

    typedef logic [HZD_MAX_STG-1:0] stg_vec_t;

    // Bits [n-1:0] set, everything above clear.
    function automatic stg_vec_t low_mask(input int n);
        stg_vec_t m;
        for (int i = 0; i < HZD_MAX_STG; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

    function automatic stg_vec_t one_bit(input int idx);
        stg_vec_t m;
        for (int i = 0; i < HZD_MAX_STG; i++) begin
            m[i] = (i == idx);
        end
        return m;
    endfunction

endpackage

// File: rtl/pipe_hzd_ctrl_if.sv
// Hazard-source and pipeline-control bundle between the core datapath and the hazard controller.
// The master side is the pipeline raising hazards; the slave side is the controller.
interface pipe_hzd_ctrl_if #(
    parameter int NUM_STG = 4,
    parameter int CNT_W   = 16
);

    logic               mem_miss;
    logic               mem_rdy;
    logic               branch_taken;
    logic               load_use;
    logic               pc_we;
    logic [NUM_STG-1:0] we;
    logic [NUM_STG-1:0] clr;
    logic               busy;
    logic [CNT_W-1:0]   hzd_cyc;

    modport master (
        output mem_miss, mem_rdy, branch_taken, load_use,
        input  pc_we, we, clr, busy, hzd_cyc
    );

    modport slave (
        input  mem_miss, mem_rdy, branch_taken, load_use,
        output pc_we, we, clr, busy, hzd_cyc
    );

endinterface

// File: rtl/hzd_sat_cnt.sv
// Generic W-bit up-counter that sticks at all ones instead of wrapping.
module hzd_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_hzd_ctrl.sv
// Stateful hazard sequencer: arbitrates cache-miss, branch and load-use hazards and drives
// the pipeline register we/clr pins. Outputs are Mealy so RUN responds in the same cycle.
module pipe_hzd_ctrl
    import hzd_pkg::*;
#(
    parameter int NUM_STG = 4,
    parameter int BR_STG  = 1,
    parameter int LU_CYC  = 1,
    parameter int CNT_W   = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    pipe_hzd_ctrl_if.slave hz
);

    localparam stg_vec_t ONES_W = low_mask(NUM_STG);
    localparam stg_vec_t BR_W   = low_mask(BR_STG + 1);
    localparam stg_vec_t TOP_W  = one_bit(NUM_STG - 1);
    localparam stg_vec_t B0_W   = one_bit(0);
    localparam stg_vec_t B1_W   = one_bit(1);

    localparam logic [NUM_STG-1:0] ALL_ONES  = ONES_W[NUM_STG-1:0];
    localparam logic [NUM_STG-1:0] BR_CLR    = BR_W[NUM_STG-1:0];
    localparam logic [NUM_STG-1:0] MISS_MASK = TOP_W[NUM_STG-1:0];
    localparam logic [NUM_STG-1:0] LU_WE     = ALL_ONES & ~B0_W[NUM_STG-1:0];
    localparam logic [NUM_STG-1:0] LU_CLR    = B1_W[NUM_STG-1:0];
    localparam logic [3:0]         LU_LOAD   = 4'(LU_CYC - 1);

    hz_state_t          state, state_n;
    hz_state_t          ret_state, ret_n;
    logic [3:0]         lu_cnt, lu_cnt_n;
    logic               pc_we_c;
    logic [NUM_STG-1:0] we_c;
    logic [NUM_STG-1:0] clr_c;
    logic               new_miss;

    // A miss whose data arrives in the same cycle never stalls.
    assign new_miss = hz.mem_miss && !hz.mem_rdy;

    always_comb begin
        state_n = state;
        ret_n   = ret_state;
        lu_cnt_n = lu_cnt;
        pc_we_c = 1'b1;
        we_c    = ALL_ONES;
        clr_c   = '0;
        case (state)
            HZ_RUN: begin
                if (new_miss) begin
                    pc_we_c = 1'b0;
                    we_c    = MISS_MASK;
                    clr_c   = MISS_MASK;
                    state_n = HZ_MISS;
                    ret_n   = HZ_RUN;
                end else if (hz.branch_taken) begin
                    clr_c = BR_CLR;
                end else if (hz.load_use) begin
                    pc_we_c = 1'b0;
                    we_c    = LU_WE;
                    clr_c   = LU_CLR;
                    if (LU_CYC > 1) begin
                        state_n  = HZ_LU;
                        lu_cnt_n = LU_LOAD;
                    end
                end
            end
            HZ_MISS: begin
                // Other hazard sources are frozen behind the miss and re-evaluated after release.
                if (hz.mem_rdy) begin
                    state_n = ret_state;
                end else begin
                    pc_we_c = 1'b0;
                    we_c    = MISS_MASK;
                    clr_c   = MISS_MASK;
                end
            end
            HZ_LU: begin
                if (new_miss) begin
                    pc_we_c = 1'b0;
                    we_c    = MISS_MASK;
                    clr_c   = MISS_MASK;
                    state_n = HZ_MISS;
                    ret_n   = HZ_LU;
                end else if (hz.branch_taken) begin
                    clr_c    = BR_CLR;
                    state_n  = HZ_RUN;
                    lu_cnt_n = '0;
                end else begin
                    pc_we_c  = 1'b0;
                    we_c     = LU_WE;
                    clr_c    = LU_CLR;
                    lu_cnt_n = lu_cnt - 4'd1;
                    if (lu_cnt == 4'd1) begin
                        state_n = HZ_RUN;
                    end
                end
            end
            default: begin
                state_n = HZ_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HZ_RUN;
            ret_state <= HZ_RUN;
            lu_cnt    <= '0;
        end else begin
            state     <= state_n;
            ret_state <= ret_n;
            lu_cnt    <= lu_cnt_n;
        end
    end

    // Reset forces a full bubble with the PC held.
    assign hz.pc_we = rst_n ? pc_we_c : 1'b0;
    assign hz.we    = rst_n ? we_c : ALL_ONES;
    assign hz.clr   = rst_n ? clr_c : ALL_ONES;
    assign hz.busy  = (state != HZ_RUN);

    hzd_sat_cnt #(
        .W (CNT_W)
    ) u_hzd_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!pc_we_c || (clr_c != '0)),
        .cnt   (hz.hzd_cyc)
    );

endmodule

// File: tb/tb_pipe_hzd_ctrl.sv
// Randomized bench for pipe_hzd_ctrl against a behavioural model that tracks
// "miss outstanding" and "load-use cycles still owed" rather than controller states.
module tb_pipe_hzd_ctrl;

    localparam int NUM_STG = 4;
    localparam int BR_STG  = 1;
    localparam int LU_CYC  = 3;
    localparam int CNT_W   = 5;
    localparam int NCYC    = 4000;

    localparam int ALL_MASK  = (1 << NUM_STG) - 1;
    localparam int TOP_MASK  = 1 << (NUM_STG - 1);
    localparam int BR_MASK   = (1 << (BR_STG + 1)) - 1;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pipe_hzd_ctrl_if #(.NUM_STG(NUM_STG), .CNT_W(CNT_W)) hif ();

    pipe_hzd_ctrl #(
        .NUM_STG (NUM_STG),
        .BR_STG  (BR_STG),
        .LU_CYC  (LU_CYC),
        .CNT_W   (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hif)
    );

    int nChecks = 0;
    int nFails  = 0;

    bit mInMiss  = 1'b0;
    int mLuLeft  = 0;
    int mCount   = 0;

    int expPcWe, expWe, expClr, expBusy, expCnt;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Misses stay asserted until serviced; other sources are random each cycle.
    task automatic applyStimulus(input int cyc);
        bit missHeld;
        missHeld = hif.mem_miss && !hif.mem_rdy && rst_n;
        rst_n = (cyc < 2) ? 1'b0 : ($urandom_range(0, 199) != 0);
        hif.mem_miss = missHeld ? 1'b1 : ($urandom_range(0, 9) == 0);
        hif.mem_rdy  = hif.mem_miss ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
        hif.branch_taken = ($urandom_range(0, 7) == 0);
        hif.load_use     = ($urandom_range(0, 9) < 3);
    endtask

    task automatic setExp(input int pc, input int w, input int c);
        expPcWe = pc;
        expWe   = w;
        expClr  = c;
    endtask

    // One model cycle: derive this cycle's outputs, then advance the model.
    task automatic modelStep();
        if (!rst_n) begin
            setExp(0, ALL_MASK, ALL_MASK);
            expBusy = 0;
            expCnt  = 0;
            mInMiss = 1'b0;
            mLuLeft = 0;
            mCount  = 0;
        end else begin
            expBusy = (mInMiss || mLuLeft > 0) ? 1 : 0;
            expCnt  = mCount;
            if (mInMiss) begin
                if (hif.mem_rdy) begin
                    setExp(1, ALL_MASK, 0);
                    mInMiss = 1'b0;
                end else begin
                    setExp(0, TOP_MASK, TOP_MASK);
                end
            end else if (hif.mem_miss && !hif.mem_rdy) begin
                setExp(0, TOP_MASK, TOP_MASK);
                mInMiss = 1'b1;
            end else if (hif.branch_taken) begin
                setExp(1, ALL_MASK, BR_MASK);
                mLuLeft = 0;
            end else if (mLuLeft > 0) begin
                setExp(0, ALL_MASK - 1, 2);
                mLuLeft--;
            end else if (hif.load_use) begin
                setExp(0, ALL_MASK - 1, 2);
                mLuLeft = LU_CYC - 1;
            end else begin
                setExp(1, ALL_MASK, 0);
            end
            if ((expPcWe == 0 || expClr != 0) && mCount < CNT_MAX) begin
                mCount++;
            end
        end
    endtask

    initial begin
        hif.mem_miss     = 1'b0;
        hif.mem_rdy      = 1'b0;
        hif.branch_taken = 1'b0;
        hif.load_use     = 1'b0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            applyStimulus(cyc);
            #3;
            modelStep();
            checkOutput("pc_we", 32'(hif.pc_we), 32'(expPcWe));
            checkOutput("we", 32'(hif.we), 32'(expWe));
            checkOutput("clr", 32'(hif.clr), 32'(expClr));
            checkOutput("busy", 32'(hif.busy), 32'(expBusy));
            checkOutput("hzd_cyc", 32'(hif.hzd_cyc), 32'(expCnt));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/pipe_hzd_ctrl.md
# pipe_hzd_ctrl

Parametrised pipeline hazard controller for the in-order core. It replaces the single-cycle hazard lookup with a stateful sequencer that emits per-register write-enables and clears for `NUM_STG` pipeline registers plus the PC. It holds multi-cycle cache-miss stalls, multi-cycle load-use stalls and branch flushes, arbitrates among them, and counts hazard cycles. It sits beside the pipeline registers and drives their `we`/`clr` pins directly.

## Interface
- `NUM_STG`, 4, number of pipeline registers; index 0 = IF/ID, `NUM_STG-1` = MEM/WB (must be ≥3)
- `BR_STG`, 1, highest register index cleared on a taken branch (registers 0..`BR_STG` are flushed); 0 ≤ `BR_STG` ≤ `NUM_STG-3`
- `LU_CYC`, 1, stall cycles per load-use hazard (1..15)
- `CNT_W`, 16, width of the hazard-cycle counter
- `clk`, in, 1, core clock
- `rst_n`, in, 1, asynchronous active-low reset
- `mem_miss`, in, 1, D-cache miss for the instruction in MEM; level, held until serviced
- `mem_rdy`, in, 1, one-cycle pulse: miss data returned
- `branch_taken`, in, 1, taken or mispredicted branch resolved; level, one cycle per branch
- `load_use`, in, 1, load-use dependency detected in ID
- `pc_we`, out, 1, PC write enable
- `we`, out, `NUM_STG`, pipeline register write enables
- `clr`, out, `NUM_STG`, pipeline register synchronous clears (bubble insert)
- `busy`, out, 1, controller is in a multi-cycle state
- `hzd_cyc`, out, `CNT_W`, saturating count of cycles with `pc_we`=0 or any `clr` bit set

## Operation
- States: RUN, MISS_WAIT, LU_STALL.
- Priority in RUN: miss > branch > load-use. No hazard: `pc_we`=1, `we`=all 1, `clr`=0.
- Miss (`mem_miss`=1, `mem_rdy`=0): `pc_we`=0, `we[NUM_STG-2:0]`=0, `we[NUM_STG-1]`=1, `clr[NUM_STG-1]`=1. Go to MISS_WAIT. Return state is RUN.
- Miss with `mem_rdy`=1 in the same cycle: treated as serviced; no stall.
- MISS_WAIT: drives the miss outputs. `branch_taken` and `load_use` are ignored because the pipeline is frozen and the sources stay asserted. On `mem_rdy`: `pc_we`=1, `we`=all 1, `clr`=0, go to the saved return state.
- Branch: `clr[BR_STG:0]`=all 1, `we`=all 1, `pc_we`=1. Single cycle, no state change.
- Load-use: `pc_we`=0, `we[0]`=0, `clr[1]`=1, other `we`=1. If `LU_CYC`>1, load `lu_cnt`=`LU_CYC-1` and go to LU_STALL.
- LU_STALL: drives the load-use outputs. `load_use` is ignored. `lu_cnt` decrements each cycle; at `lu_cnt`==1, go to RUN at the end of the cycle.
  - `branch_taken` in LU_STALL: abort the stall. Drive branch outputs, go to RUN, clear `lu_cnt`.
  - `mem_miss` in LU_STALL: drive miss outputs, go to MISS_WAIT with return state LU_STALL. `lu_cnt` is frozen and resumes after `mem_rdy`.
- `busy` = (state ≠ RUN).
- `hzd_cyc` increments when `pc_we`=0 or `clr`≠0, and saturates at all ones.

## Timing
- In RUN, outputs are combinational from the inputs (Mealy). This gives a zero-cycle response, as the pipeline requires.
- In MISS_WAIT and LU_STALL, outputs depend on registered state, `lu_cnt` and the current `mem_rdy`/`branch_taken`/`mem_miss`.
- Load-use stalls total exactly `LU_CYC` cycles: the detection cycle plus `LU_CYC-1` in LU_STALL, excluding any frozen miss cycles.
- Miss stall length = cycles from `mem_miss` rise to `mem_rdy`, inclusive of the `mem_rdy` cycle minus one (the `mem_rdy` cycle releases).
- A `mem_rdy` pulse in RUN with no miss is ignored.
- While `rst_n`=0: state=RUN, `lu_cnt`=0, return state=RUN, `hzd_cyc`=0, `pc_we`=0, `we`=all 1, `clr`=all 1, `busy`=0.
- Deassertion takes effect at the next `clk` edge.
- Reset mid-stall abandons the stall immediately with no residue.

## Structure
- Shared package `hzd_pkg`: state enum (`HZ_RUN`, `HZ_MISS`, `HZ_LU`) and output-vector helper constants (all-ones/zero masks as functions of `NUM_STG`).
- Optional sub-module `hzd_sat_cnt` (generic saturating counter, parameter `W`) for `hzd_cyc`.
- The next-state logic and output decoder stay in one `always_comb`.

## Test plan
- Defaults, `load_use` pulse in RUN → one cycle of `pc_we`=0, `we`=4'b1110, `clr`=4'b0010, then normal; `hzd_cyc`=1.
- `LU_CYC`=3, `load_use` held 3 cycles → stall for exactly 3 cycles, `busy`=1 for cycles 2–3, then `we`=4'b1111.
- `mem_miss` high 5 cycles, `mem_rdy` in cycle 5 → cycles 1–4 `pc_we`=0, `we`=4'b1000, `clr`=4'b1000; cycle 5 all released; `hzd_cyc`=4.
- `mem_miss` and `branch_taken` both high → miss outputs win. After `mem_rdy`, the held `branch_taken` yields `clr`=4'b0011 for 1 cycle.
- `LU_CYC`=4. Miss arrives in LU_STALL with `lu_cnt`=2 and lasts 3 cycles → after `mem_rdy`, exactly 2 more load-use cycles, then RUN.
- `LU_CYC`=3, `branch_taken` in the 2nd stall cycle → `clr`=4'b0011, `pc_we`=1 that cycle, state RUN next cycle. Then assert `rst_n`=0 mid-MISS_WAIT → outputs at reset values immediately.
